// File: rtl/pwm_secuenciador.sv
// ---------------------------------------------------------------------------
// pwm_secuenciador
// Plays an 8-entry duty table as a PWM sequence. Each table step is held for
// REPS PWM periods. A period lasts 2^R counts, and each count lasts 2^DIV clk
// cycles. The sequence either finishes after the last step or loops back to
// step 0.
//
// Ports
//   clk, reset     : clock, asynchronous active-high reset
//   start, stop    : begin sequence (level-sampled in IDLE), abort sequence
//   loop_en        : restart at step 0 after the last step instead of ending
//   wr_en/addr/data: duty table write port, accepted in any state
//   pwm_out        : registered PWM output
//   busy           : high exactly while the sequence runs
//   step_idx       : current table step
//   done           : one-cycle pulse when the sequence ends normally
//   period_tick    : one-cycle pulse at the end of every PWM period
// ---------------------------------------------------------------------------
module pwm_secuenciador #(
  parameter int R       = 8,
  parameter int DIV     = 2,
  parameter int REPS    = 1,
  parameter int N_PASOS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         loop_en,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [R-1:0] wr_data,
  output logic         pwm_out,
  output logic         busy,
  output logic [2:0]   step_idx,
  output logic         done,
  output logic         period_tick
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [7:0] INIT [8] = '{8'hBE, 8'hFF, 8'h88, 8'h99,
                                      8'h66, 8'h33, 8'h00, 8'h99};

  state_t         state;
  logic [DIV-1:0] pre;
  logic [R-1:0]   cnt;
  logic [R-1:0]   duty_q;
  logic [7:0]     rep;
  logic [R-1:0]   table_q [N_PASOS];

  logic           tick;
  logic           wrap;
  logic           last_rep;
  logic           last_step;
  logic           finish;
  logic [2:0]     next_step;

  assign tick      = (state == RUN) && (pre == {DIV{1'b1}});
  assign wrap      = tick && (cnt == {R{1'b1}});
  assign last_rep  = (rep == 8'(REPS - 1));
  assign last_step = (step_idx == 3'(N_PASOS - 1));
  assign finish    = wrap && last_rep && last_step && !loop_en;

  // Step that becomes active at this period end. When the sequence ends,
  // the index stays on the last step.
  always_comb begin
    next_step = step_idx;
    if (wrap && last_rep) begin
      if (last_step) next_step = loop_en ? 3'd0 : step_idx;
      else           next_step = step_idx + 3'd1;
    end
  end

  // Duty table. A write that coincides with a latch of the same entry is
  // not seen by that latch, because duty_q samples the old register value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PASOS; i++) table_q[i] <= R'(INIT[i]);
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pre         <= '0;
      cnt         <= '0;
      duty_q      <= '0;
      rep         <= '0;
      step_idx    <= '0;
      pwm_out     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      done        <= 1'b0;
      period_tick <= 1'b0;
      case (state)
        IDLE: begin
          pwm_out <= 1'b0;
          pre     <= '0;
          cnt     <= '0;
          if (start && !stop) begin
            state    <= RUN;
            busy     <= 1'b1;
            step_idx <= 3'd0;
            rep      <= '0;
            duty_q   <= table_q[0];
          end
        end
        RUN: begin
          if (stop) begin
            // Abort. Output and busy drop on the same edge, and no done pulse.
            state   <= IDLE;
            busy    <= 1'b0;
            pwm_out <= 1'b0;
            pre     <= '0;
            cnt     <= '0;
            rep     <= '0;
          end else begin
            pre     <= pre + DIV'(1);
            pwm_out <= (cnt < duty_q);
            if (tick) cnt <= cnt + R'(1);
            if (wrap) begin
              // Period boundary is the only point where the duty may change.
              period_tick <= 1'b1;
              duty_q      <= table_q[next_step];
              step_idx    <= next_step;
              rep         <= last_rep ? 8'd0 : rep + 8'd1;
              if (finish) begin
                state   <= FIN;
                busy    <= 1'b0;
                done    <= 1'b1;
                pwm_out <= 1'b0;
              end
            end
          end
        end
        FIN: begin
          state   <= IDLE;
          pwm_out <= 1'b0;
          pre     <= '0;
          cnt     <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
